// File: rtl/uart_tx_paridad.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 parity bit, 1 stop bit.
// A frame starts on a rising edge of transmit seen while idle; busy covers the whole frame, done pulses once after it.
module uart_tx_paridad #(
    parameter int CLKS_PER_BIT = 5208,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       transmit,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] o_state
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shreg;
    logic            r_parity;
    logic            r_prev;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    logic            w_start;
    logic            w_bit_end;

    // A held transmit never restarts: only a low-to-high transition seen in IDLE counts.
    assign w_start   = transmit & ~r_prev & (r_state == IDLE);
    assign w_bit_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shreg  <= '0;
            r_parity <= 1'b0;
            r_prev   <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_prev <= transmit;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_start) begin
                        r_shreg  <= data_in;
                        r_parity <= (^data_in) ^ PARITY_ODD;
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shreg[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shreg <= {1'b0, r_shreg[7:1]};
                        // The next bit to send is shreg[1] because the shift lands on this same edge.
                        if (r_bit == 3'd7) begin
                            r_state <= PARITY;
                            r_tx    <= r_parity;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shreg[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign o_state = r_state;

endmodule
